uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Transmit stage of the UART: pops 8-bit words from the TX FIFO (first-word fall-through),
//  frames them as start / data / parity / stop, and drives the serial TX line.
//  Frame format comes from the active uart_config_s (data_width, stop_bits, parity_mode).
//  Bit timing comes from an external 16x oversampling baud tick.
//  Sits between the TX FIFO and the tx pin; the main control FSM owns enable and config.
// PARAMETERS
//  OVERSAMPLE  16  ov_baud_tick_i pulses per bit period; must be even (1.5 stop = 3*OVERSAMPLE/2)
// PORTS
//  clk_i            in   1  system clock (SYSTEM_CLOCK_FREQ)
//  rst_i            in   1  synchronous, active-high reset
//  ov_baud_tick_i   in   1  one-clk pulse, OVERSAMPLE per bit period
//  tx_enable_i      in   1  allow new frames to start
//  fifo_empty_i     in   1  TX FIFO empty
//  fifo_data_i      in   8  TX FIFO head word (FWFT, valid whenever !fifo_empty_i)
//  fifo_read_o      out  1  one-clk pop strobe
//  data_width_i     in   2  DW_5BIT..DW_8BIT
//  stop_bits_i      in   2  SB_1BIT / SB_15BIT / RESERVED / SB_2BIT
//  parity_mode_i    in   2  DISABLED_1 / EVEN / DISABLED_2 / ODD
//  tx_o             out  1  serial line, idle high
//  busy_o           out  1  frame in progress (state != IDLE)
//  tx_done_o        out  1  one-clk pulse when last stop bit completes
// BEHAVIOUR
//  Reset: state=IDLE, tx_o=1, busy_o=0, fifo_read_o=0, tx_done_o=0, all counters=0.
//  FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: if tx_enable_i && !fifo_empty_i: assert fifo_read_o for exactly 1 clk.
//   - Same cycle: latch fifo_data_i and the three config fields.
//   - Next clk: enter START, tx_o=0.
//   - Config changes mid-frame have no effect until the next frame.
//  Tick counter: cleared on every state entry; advances only on ov_baud_tick_i.
//   - A bit ends on the clk the counter reaches OVERSAMPLE-1 while ov_baud_tick_i=1.
//  START: tx_o=0 for OVERSAMPLE ticks.
//  DATA: width = 5 + data_width code; LSB first; bit index 0..width-1.
//   - After the last bit: go to PARITY if parity_mode[0]=1, else STOP.
//  PARITY: even parity bit = XOR of the transmitted data bits only; ODD = its inverse.
//   - Bits above the configured width are excluded from the XOR.
//  STOP: tx_o=1 for OVERSAMPLE ticks (SB_1BIT, RESERVED), 3*OVERSAMPLE/2 (SB_15BIT),
//   or 2*OVERSAMPLE (SB_2BIT).
//   - On completion: tx_done_o pulses 1 clk and state returns to IDLE.
//  Back-to-back: with FIFO non-empty and enable high, the next fifo_read_o comes 1 clk after tx_done_o.
//  tx_enable_i deasserted mid-frame: the current frame completes; no new pop occurs.
//  fifo_read_o never asserts while fifo_empty_i=1 or while busy_o=1.
//  Reset mid-frame: tx_o=1 and state=IDLE on the next clk; the partial frame is dropped.
//  ov_baud_tick_i ignored in IDLE; tx_o is glitch-free (registered output).
// TESTING
//  8 bit, EVEN, 2 stop, word 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,(p)0,1,1 per bit; 192 ticks; 1 tx_done_o.
//  5 bit, DISABLED_1, 1 stop, word 0xFF -> 0,1,1,1,1,1,1; 112 ticks total; upper 3 bits never sent.
//  7 bit, ODD, 1.5 stop, word 0x55 -> data 1010101, parity 1, stop lasts 24 ticks; frame 168 ticks.
//  3 words in FIFO, enable held -> 3 frames; each fifo_read_o exactly 1 clk after prior tx_done_o.
//  rst_i at tick 50 of a frame -> tx_o=1, busy_o=0 next clk; FIFO not popped again until rst_i=0.
//  tx_enable_i dropped during DATA -> frame finishes intact; no further fifo_read_o while low.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames FIFO words as start/data/parity/stop and drives the UART TX line
// Bit timing comes from an external oversampling tick; the frame config is latched once per word.
module uart_tx_serializer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ov_baud_tick_i,
   input  logic       tx_enable_i,
   input  logic       fifo_empty_i,
   input  logic [7:0] fifo_data_i,
   output logic       fifo_read_o,
   input  logic [1:0] data_width_i,
   input  logic [1:0] stop_bits_i,
   input  logic [1:0] parity_mode_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       tx_done_o
);
   localparam int CW = $clog2(2 * OVERSAMPLE);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t        state;
   logic [CW-1:0] cnt, last_tick;
   logic [2:0]    bit_idx, last_bit;
   logic [7:0]    data;
   logic [1:0]    dw, sb, pm;
   logic          bit_end, par_bit;
   assign busy_o = state != IDLE;
   // The pop is held off during the done cycle so back-to-back pops land one clk after tx_done_o.
   assign fifo_read_o = state == IDLE && !rst_i && !tx_done_o && tx_enable_i && !fifo_empty_i;
   always_comb begin
      last_tick = state != STOP ? CW'(OVERSAMPLE - 1) :
                  sb == 2'b01   ? CW'(3 * OVERSAMPLE / 2 - 1) :
                  sb == 2'b11   ? CW'(2 * OVERSAMPLE - 1) : CW'(OVERSAMPLE - 1);
      bit_end   = ov_baud_tick_i && cnt == last_tick;
      last_bit  = 3'd4 + {1'b0, dw};
      par_bit   = ^(data & (8'hFF >> (2'd3 - dw))) ^ pm[1];
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         tx_o      <= 1'b1;
         tx_done_o <= 1'b0;
         cnt       <= '0;
         bit_idx   <= '0;
         data      <= '0;
         dw        <= '0;
         sb        <= '0;
         pm        <= '0;
      end else begin
         tx_done_o <= 1'b0;
         cnt       <= (bit_end || state == IDLE) ? '0 : cnt + CW'(ov_baud_tick_i);
         case (state)
            IDLE: if (fifo_read_o) begin
               data  <= fifo_data_i;
               dw    <= data_width_i;
               sb    <= stop_bits_i;
               pm    <= parity_mode_i;
               state <= START;
               tx_o  <= 1'b0;
            end
            START: if (bit_end) begin
               state   <= DATA;
               bit_idx <= '0;
               tx_o    <= data[0];
            end
            DATA: if (bit_end) begin
               if (bit_idx == last_bit) begin
                  state <= pm[0] ? PARITY : STOP;
                  tx_o  <= pm[0] ? par_bit : 1'b1;
               end else begin
                  bit_idx <= bit_idx + 3'd1;
                  tx_o    <= data[bit_idx + 3'd1];
               end
            end
            PARITY: if (bit_end) begin
               state <= STOP;
               tx_o  <= 1'b1;
            end
            STOP: if (bit_end) begin
               state     <= IDLE;
               tx_done_o <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: FIFO model feeds the serializer; popped words are scoreboarded
// and compared against frames decoded from tx_o at the middle of each bit period.
module tb_uart_tx_serializer;
   localparam int OV = 16;
   typedef struct packed {logic [7:0] w; logic [1:0] dw, sb, pm;} exp_t;
   logic       clk_i = 0, rst_i = 1, ov_baud_tick_i = 0, tx_enable_i = 0, fifo_empty_i = 1;
   logic [7:0] fifo_data_i = 0;
   logic [1:0] data_width_i = 0, stop_bits_i = 0, parity_mode_i = 0;
   logic       fifo_read_o, tx_o, busy_o, tx_done_o;
   logic [7:0] fifo_q[$];
   exp_t       exp_q[$];
   int         errors = 0, checks = 0, frames = 0, tick_ph = 0;
   bit         abort = 0;
   uart_tx_serializer #(.OVERSAMPLE(OV)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ov_baud_tick_i(ov_baud_tick_i), .tx_enable_i(tx_enable_i),
      .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_read_o(fifo_read_o),
      .data_width_i(data_width_i), .stop_bits_i(stop_bits_i), .parity_mode_i(parity_mode_i),
      .tx_o(tx_o), .busy_o(busy_o), .tx_done_o(tx_done_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic void model(input exp_t e, output logic [15:0] bits, output int n, output int ticks);
      int   w;
      logic par;
      w = 5 + int'(e.dw);
      bits = '0;
      for (int i = 0; i < w; i++) bits[1 + i] = e.w[i];
      n = 1 + w;
      if (e.pm[0]) begin
         par = e.pm[1];
         for (int i = 0; i < w; i++) par ^= e.w[i];
         bits[n] = par;
         n++;
      end
      bits[n] = 1'b1;
      n++;
      if (e.sb == 2'd3) begin
         bits[n] = 1'b1;
         n++;
      end
      ticks = (1 + w + int'(e.pm[0])) * OV + (e.sb == 2'd1 ? 3 * OV / 2 : e.sb == 2'd3 ? 2 * OV : OV);
   endfunction
   always @(negedge clk_i) begin
      tick_ph = (tick_ph + 1) % 4;
      ov_baud_tick_i = tick_ph == 0;
      fifo_empty_i = fifo_q.size() == 0;
      fifo_data_i = fifo_empty_i ? 8'h00 : fifo_q[0];
   end
   always @(posedge clk_i) begin
      if (fifo_read_o && fifo_q.size() > 0) begin
         exp_q.push_back({fifo_data_i, data_width_i, stop_bits_i, parity_mode_i});
         void'(fifo_q.pop_front());
      end
   end
   initial begin : mon
      bit         active, prev_done;
      int         tk, nb, en, et;
      logic [15:0] got, eb;
      exp_t       e;
      active = 0; prev_done = 0; tk = 0; nb = 0; got = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (prev_done) begin
            chk("done_pulse", tx_done_o, 0);
            if (tx_enable_i && !fifo_empty_i) chk("b2b_pop", fifo_read_o, 1);
         end
         prev_done = 0;
         if (fifo_read_o) chk("pop_guard", {fifo_empty_i, busy_o, !tx_enable_i, rst_i}, 0);
         if (active) begin
            if (ov_baud_tick_i) tk++;
            if (!busy_o) begin
               active = 0;
               if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  if (!abort) begin
                     model(e, eb, en, et);
                     chk("frame_bits", got, eb);
                     chk("frame_nbits", nb, en);
                     chk("frame_ticks", tk, et);
                     chk("done", tx_done_o, 1);
                     prev_done = 1;
                     frames++;
                  end
               end
            end else if (ov_baud_tick_i && tk % OV == OV / 2) begin
               got[nb] = tx_o;
               nb++;
            end
         end else if (busy_o) begin
            active = 1; tk = 0; nb = 0; got = '0;
         end
      end
   end
   task automatic cfg(input logic [1:0] dw, input logic [1:0] sb, input logic [1:0] pm);
      data_width_i = dw; stop_bits_i = sb; parity_mode_i = pm;
   endtask
   task automatic wait_idle();
      repeat (2) @(posedge clk_i);
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk_i);
         #1;
         if (!busy_o && fifo_q.size() == 0 && exp_q.size() == 0) return;
      end
      chk("idle_timeout", 0, 1);
   endtask
   task automatic wait_busy(input logic lvl);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk_i);
         #1;
         if (busy_o == lvl) return;
      end
      chk("busy_timeout", busy_o, lvl);
   endtask
   task automatic send(input logic [1:0] dw, input logic [1:0] sb, input logic [1:0] pm, input logic [7:0] w);
      cfg(dw, sb, pm);
      fifo_q.push_back(w);
      wait_idle();
   endtask
   initial begin
      int f0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_tx", tx_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_read", fifo_read_o, 0);
      chk("rst_done", tx_done_o, 0);
      cfg(2'd3, 2'd3, 2'd1);
      fifo_q.push_back(8'hA5);
      tx_enable_i = 1;
      repeat (4) @(posedge clk_i);
      #1;
      chk("no_pop_in_rst", fifo_q.size(), 1);
      rst_i = 0;
      wait_idle();
      cfg(2'd0, 2'd0, 2'd0);
      fifo_q.push_back(8'hFF);
      repeat (20) @(posedge clk_i);
      cfg(2'd3, 2'd3, 2'd1);
      wait_idle();
      send(2'd2, 2'd1, 2'd3, 8'h55);
      f0 = frames;
      cfg(2'd3, 2'd0, 2'd3);
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'hC3);
      wait_idle();
      chk("b2b_frames", frames - f0, 3);
      cfg(2'd3, 2'd0, 2'd0);
      fifo_q.push_back(8'h81);
      fifo_q.push_back(8'h7E);
      wait_busy(1);
      repeat (160) @(posedge clk_i);
      #1;
      tx_enable_i = 0;
      wait_busy(0);
      repeat (300) @(posedge clk_i);
      #1;
      chk("en_low_hold", fifo_q.size(), 1);
      chk("en_low_idle", busy_o, 0);
      tx_enable_i = 1;
      wait_idle();
      fifo_q.push_back(8'h3C);
      wait_busy(1);
      repeat (200) @(posedge clk_i);
      #1;
      abort = 1;
      rst_i = 1;
      fifo_q.push_back(8'h99);
      @(posedge clk_i);
      #1;
      chk("rst_mid_tx", tx_o, 1);
      chk("rst_mid_busy", busy_o, 0);
      repeat (10) @(posedge clk_i);
      #1;
      chk("rst_hold_fifo", fifo_q.size(), 1);
      rst_i = 0;
      abort = 0;
      wait_idle();
      for (int i = 0; i < 6; i++)
         send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
      repeat (5) @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
